shift_load_sequencer: RTL and testbench

//  Command-driven controller directly upstream of the 4-bit bidirectional shift register.

---
 rtl/shift_seq_pkg.sv | 17 +
 rtl/shift_seq_counter.sv | 36 +++
 rtl/shift_load_sequencer.sv | 139 +++++++++++++
 tb/tb_shift_load_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the shift-register command sequencer.
package shift_seq_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_seq_counter.sv
// Loadable down-counter for the shift window; saturates at zero instead of wrapping.
module shift_seq_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             is_one_o,
  output logic             is_zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one_o  = (cnt_q == CNT_W'(1));
  assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/shift_load_sequencer.sv
// Drives load/dir/d_in of a bidirectional shift register: one load, then cmd_count shifts.
// Optional macro RESULT_CAPTURE_EN: capture q_in into result on the DONE cycle.
module shift_load_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  input  logic [WIDTH-1:0] q_in,
  output logic             load,
  output logic             dir,
  output logic [WIDTH-1:0] d_in,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] result
);

  state_e           state_q, state_d;
  logic             accept, abort_hit, cnt_load, cnt_dec;
  logic             cnt_is_one, cnt_is_zero;
  logic [CNT_W-1:0] count_q;
  logic             load_q, dir_q, shift_en_q, busy_q, done_q, aborted_q;
  logic [WIDTH-1:0] d_in_q;

  shift_seq_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(count_q),
    .dec_i     (cnt_dec),
    .is_one_o  (cnt_is_one),
    .is_zero_o (cnt_is_zero)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    abort_hit = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        // A start that coincides with abort is silently dropped.
        if (start && !abort) begin
          accept  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_load = 1'b1;
        if (abort) begin
          abort_hit = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = (count_q != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (abort) begin
          abort_hit = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_is_one || cnt_is_zero) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      load_q     <= 1'b0;
      dir_q      <= 1'b0;
      d_in_q     <= '0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= (state_d == LOAD);
      shift_en_q <= (state_d == SHIFT);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
      aborted_q  <= abort_hit;
      if (accept) begin
        count_q <= cmd_count;
        d_in_q  <= cmd_data;
        dir_q   <= cmd_dir;
      end
    end
  end

  assign load     = load_q;
  assign dir      = dir_q;
  assign d_in     = d_in_q;
  assign shift_en = shift_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;

`ifdef RESULT_CAPTURE_EN
  logic [WIDTH-1:0] result_q;

  // During DONE the downstream register holds the value after the final counted shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else if (state_q == DONE) begin
      result_q <= q_in;
    end
  end

  assign result = result_q;
`else
  logic unused_q_in;
  assign unused_q_in = ^q_in;
  assign result      = '0;
`endif

endmodule

// File: tb/tb_shift_load_sequencer.sv
// Command-table bench for shift_load_sequencer with a behavioural downstream shift register.
module tb_shift_load_sequencer;
  import shift_seq_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, start, cmd_dir, abort;
  logic [WIDTH-1:0] cmd_data, q_in, d_in, result;
  logic [CNT_W-1:0] cmd_count;
  logic             load, dir, shift_en, busy, done, aborted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_load_sequencer #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cmd_data (cmd_data),
    .cmd_dir  (cmd_dir),
    .cmd_count(cmd_count),
    .abort    (abort),
    .q_in     (q_in),
    .load     (load),
    .dir      (dir),
    .d_in     (d_in),
    .shift_en (shift_en),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .result   (result)
  );

  // Downstream register: loads on load, otherwise shifts with zero fill.
  logic [WIDTH-1:0] sr_q = '0;
  always @(posedge clk) begin
    if (load)                sr_q <= d_in;
    else if (dir == DIR_LEFT) sr_q <= sr_q << 1;
    else                     sr_q <= sr_q >> 1;
  end
  assign q_in = sr_q;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] data;
    logic             dir;
    logic [CNT_W-1:0] count;
    int               abort_k;    // cycle after start that abort is held (0 = none)
    int               restart_k;  // cycle after start that a stray start is driven (0 = none)
  } vec_t;

  typedef struct {
    int               load_n;
    int               shift_n;
    int               busy_n;
    int               done_n;
    int               done_k;
    int               ab_n;
    int               ab_k;
    int               dir_bad;
    logic [WIDTH-1:0] d_in;
    logic             dir;
    logic [WIDTH-1:0] result;
  } exp_t;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] exp_result = '0;
  vec_t             vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] v, input logic d,
                                               input logic [CNT_W-1:0] n);
    logic [WIDTH-1:0] r;
    r = v;
    for (int i = 0; i < int'(n); i++) r = d ? (r << 1) : (r >> 1);
    return r;
  endfunction

  task automatic run_cmd(input vec_t v);
    exp_t e, a;
    bit   ab, timed_out;
    int   k;
    ab        = (v.abort_k >= 1) && (v.abort_k <= int'(v.count) + 1);
    e.load_n  = 1;
    e.shift_n = ab ? v.abort_k - 1 : int'(v.count);
    e.busy_n  = ab ? v.abort_k : int'(v.count) + 2;
    e.done_n  = ab ? 0 : 1;
    e.done_k  = ab ? 0 : int'(v.count) + 2;
    e.ab_n    = ab ? 1 : 0;
    e.ab_k    = ab ? v.abort_k + 1 : 0;
    e.dir_bad = 0;
    e.d_in    = v.data;
    e.dir     = v.dir;
`ifdef RESULT_CAPTURE_EN
    if (!ab) exp_result = shifted(v.data, v.dir, v.count);
`endif
    e.result = exp_result;
    sb_q.push_back(e);

    a.load_n = 0; a.shift_n = 0; a.busy_n = 0; a.done_n = 0; a.done_k = 0;
    a.ab_n = 0; a.ab_k = 0; a.dir_bad = 0; a.d_in = '0; a.dir = 1'b0; a.result = '0;

    cmd_data = v.data; cmd_dir = v.dir; cmd_count = v.count; start = 1'b1; abort = 1'b0;
    k = 0;
    timed_out = 1'b1;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (load) begin
        a.load_n++;
        if (a.load_n == 1) begin a.d_in = d_in; a.dir = dir; end
      end
      if (shift_en) begin
        a.shift_n++;
        if (dir !== v.dir) a.dir_bad++;
      end
      if (busy) a.busy_n++;
      if (done) begin a.done_n++; a.done_k = k; end
      if (aborted) begin a.ab_n++; a.ab_k = k; end
      start = (k == v.restart_k);
      if (start) begin cmd_data = ~v.data; cmd_dir = ~v.dir; cmd_count = 4'd1; end
      abort = (k == v.abort_k);
      if (!busy) begin timed_out = 1'b0; break; end
    end
    start = 1'b0; abort = 1'b0;
    a.result = result;

    e = sb_q.pop_front();
    chk({v.name, ".timeout"}, 32'(timed_out), 0);
    chk({v.name, ".load_n"}, a.load_n, e.load_n);
    chk({v.name, ".d_in"}, a.d_in, e.d_in);
    chk({v.name, ".dir"}, a.dir, e.dir);
    chk({v.name, ".shift_n"}, a.shift_n, e.shift_n);
    chk({v.name, ".dir_held"}, a.dir_bad, e.dir_bad);
    chk({v.name, ".busy_n"}, a.busy_n, e.busy_n);
    chk({v.name, ".done_n"}, a.done_n, e.done_n);
    chk({v.name, ".done_k"}, a.done_k, e.done_k);
    chk({v.name, ".aborted_n"}, a.ab_n, e.ab_n);
    chk({v.name, ".aborted_k"}, a.ab_k, e.ab_k);
    chk({v.name, ".result"}, a.result, e.result);
    @(negedge clk);
    chk({v.name, ".idle_pulses"}, {30'd0, done, aborted}, 0);
    $display("cmd %s data=%b dir=%b count=%0d shifts=%0d busy=%0d done_k=%0d aborted_k=%0d result=%b",
             v.name, v.data, v.dir, v.count, a.shift_n, a.busy_n, a.done_k, a.ab_k, a.result);
  endtask

  initial begin
    vecs[0] = '{"cmd_r4",          4'b1010, 1'b0, 4'd4,  0, 0};
    vecs[1] = '{"cmd_cnt0",        4'b0110, 1'b0, 4'd0,  0, 0};
    vecs[2] = '{"cmd_l15_restart", 4'b1011, 1'b1, 4'd15, 0, 6};
    vecs[3] = '{"cmd_l1",          4'b0011, 1'b1, 4'd1,  0, 0};
    vecs[4] = '{"abort_shift2",    4'b1100, 1'b1, 4'd5,  3, 0};
    vecs[5] = '{"cmd_r2",          4'b1110, 1'b0, 4'd2,  0, 0};
    vecs[6] = '{"abort_load",      4'b1111, 1'b0, 4'd7,  1, 0};
    vecs[7] = '{"abort_done",      4'b1001, 1'b0, 4'd2,  4, 0};

    // Reset with a start held: nothing may happen.
    rst = 1'b1; start = 1'b1; abort = 1'b0;
    cmd_data = 4'hF; cmd_dir = 1'b1; cmd_count = 4'd3;
    repeat (2) begin
      @(negedge clk);
      chk("reset.outputs", {load, dir, d_in, shift_en, busy, done, aborted, result}, 0);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("reset.start_ignored", {load, busy}, 0);
    $display("reset applied, outputs cleared");

    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i]);
    end

    // start and abort together in IDLE: command dropped, no pulses.
    cmd_data = 4'b0101; cmd_dir = 1'b0; cmd_count = 4'd3; start = 1'b1; abort = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("start_abort.quiet", {load, shift_en, busy, done, aborted}, 0);
    end
    $display("start+abort in idle: busy=%b aborted=%b", busy, aborted);

    // Reset in the middle of a long command.
    cmd_data = 4'b1000; cmd_dir = 1'b0; cmd_count = 4'd10; start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midreset.shifting", shift_en, 1);
    rst = 1'b1;
    exp_result = '0;
    @(negedge clk);
    chk("midreset.outputs", {load, dir, d_in, shift_en, busy, done, aborted, result}, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midreset.no_pulse", {busy, done, aborted}, 0);
    end
    $display("reset mid-command: busy=%b done=%b aborted=%b", busy, done, aborted);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
